// File: rtl/fifo_pkg.sv
// Shared sizing and reset constants for the FIFO pointer/flag controller.
package fifo_pkg;
  localparam int DEF_ADDR_SIZE = 2;
  localparam int PTR_W = DEF_ADDR_SIZE + 1;
  localparam logic [PTR_W-1:0] PTR_RST = '0;
endpackage

// File: rtl/fifo_ctrl_if.sv
// Producer/consumer request and memory-control bundle for fifo_ctrl.
// Error flags exist only when FIFO_ERR_FLAGS_EN is defined.
interface fifo_ctrl_if #(
  parameter int FIFO_ADDRESS_SIZE = fifo_pkg::DEF_ADDR_SIZE
);
  logic                         wr_req;
  logic                         rd_req;
  logic                         cw_en;
  logic                         cr_en;
  logic [FIFO_ADDRESS_SIZE:0]   w_ptr;
  logic [FIFO_ADDRESS_SIZE:0]   r_ptr;
  logic                         full;
  logic                         empty;
  logic [FIFO_ADDRESS_SIZE:0]   count;
  logic                         rvalid;
`ifdef FIFO_ERR_FLAGS_EN
  logic                         overflow;
  logic                         underflow;
`endif

  modport master (
    output wr_req, rd_req,
    input  cw_en, cr_en, w_ptr, r_ptr, full, empty, count, rvalid
`ifdef FIFO_ERR_FLAGS_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  wr_req, rd_req,
    output cw_en, cr_en, w_ptr, r_ptr, full, empty, count, rvalid
`ifdef FIFO_ERR_FLAGS_EN
    , output overflow, underflow
`endif
  );
endinterface

// File: rtl/fifo_ptr.sv
// Wrap-bit-extended FIFO pointer: increments by one on en, modulo 2^W.
// Single-cycle update; synchronous active-high reset has priority.
module fifo_ptr import fifo_pkg::*; #(
  parameter int W = PTR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] ptr
);
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= W'(PTR_RST);
    end else if (en) begin
      ptr <= ptr + W'(1);
    end
  end
endmodule

// File: rtl/fifo_ctrl.sv
// FIFO pointer/flag controller: gated strobes, pointers, full/empty/count, rvalid one cycle after cr_en.
// Full rejects writes, empty rejects reads; sticky overflow/underflow only with FIFO_ERR_FLAGS_EN.
module fifo_ctrl import fifo_pkg::*; #(
  parameter int FIFO_ADDRESS_SIZE = DEF_ADDR_SIZE
) (
  input  logic        clk,
  input  logic        rst,
  fifo_ctrl_if.slave  bus
);
  localparam int AW = FIFO_ADDRESS_SIZE;
  localparam int PW = FIFO_ADDRESS_SIZE + 1;

  logic [PW-1:0] w_ptr;
  logic [PW-1:0] r_ptr;
  logic          full;
  logic          empty;
  logic          cw_en;
  logic          cr_en;
  logic          rvalid_q;

  assign empty = (w_ptr == r_ptr);
  assign full  = (w_ptr[AW] != r_ptr[AW]) && (w_ptr[AW-1:0] == r_ptr[AW-1:0]);

  // Strobes are killed during reset so the memory never sees a write that the pointers discard.
  assign cw_en = bus.wr_req & ~full  & ~rst;
  assign cr_en = bus.rd_req & ~empty & ~rst;

  fifo_ptr #(.W(PW)) u_wptr (
    .clk (clk),
    .rst (rst),
    .en  (cw_en),
    .ptr (w_ptr)
  );

  fifo_ptr #(.W(PW)) u_rptr (
    .clk (clk),
    .rst (rst),
    .en  (cr_en),
    .ptr (r_ptr)
  );

  // Tracks the memory's registered read output.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= cr_en;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wr_req && full)  overflow_q  <= 1'b1;
      if (bus.rd_req && empty) underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

  assign bus.cw_en  = cw_en;
  assign bus.cr_en  = cr_en;
  assign bus.w_ptr  = w_ptr;
  assign bus.r_ptr  = r_ptr;
  assign bus.full   = full;
  assign bus.empty  = empty;
  assign bus.count  = w_ptr - r_ptr;
  assign bus.rvalid = rvalid_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl at depth 4 with a small behavioural memory for read-data checks.
module tb_fifo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] wdata = '0;
  logic [7:0] rdata = '0;
  logic [7:0] mem [4];
  int n_checks = 0;
  int n_bad = 0;

  fifo_ctrl_if #(.FIFO_ADDRESS_SIZE(2)) bus ();

  fifo_ctrl #(.FIFO_ADDRESS_SIZE(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous memory with registered read, addressed by the low pointer bits.
  always @(posedge clk) begin
    if (bus.cw_en) mem[bus.w_ptr[1:0]] <= wdata;
    if (bus.cr_en) rdata <= mem[bus.r_ptr[1:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic e, input logic f, input int cnt);
    check({tag, ".empty"}, 32'(bus.empty), 32'(e));
    check({tag, ".full"},  32'(bus.full),  32'(f));
    check({tag, ".count"}, 32'(bus.count), 32'(cnt));
  endtask

  initial begin
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;

    // Reset: strobes forced low even with requests pending.
    bus.wr_req = 1'b1;
    @(negedge clk);
    check("rst_cw_en", 32'(bus.cw_en), 0);
    next_cycle();
    bus.wr_req = 1'b0;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_flags("reset", 1'b1, 1'b0, 0);
    check("reset.w_ptr", 32'(bus.w_ptr), 0);
    check("reset.r_ptr", 32'(bus.r_ptr), 0);
    check("reset.rvalid", 32'(bus.rvalid), 0);
    check("reset.cr_en", 32'(bus.cr_en), 0);

    // Fill with 0xA..0xD.
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      bus.wr_req = 1'b1;
      wdata = 8'(8'hA + i);
      @(negedge clk);
      check("fill.count", 32'(bus.count), 32'(i));
      check("fill.cw_en", 32'(bus.cw_en), 1);
      next_cycle();
    end
    @(negedge clk);
    check_flags("full", 1'b0, 1'b1, 4);
    check("full.cw_en", 32'(bus.cw_en), 0);
    check("full.w_ptr", 32'(bus.w_ptr), 32'b100);
    next_cycle();
    bus.wr_req = 1'b0;
    @(negedge clk);
    check("full.w_ptr_hold", 32'(bus.w_ptr), 32'b100);
`ifdef FIFO_ERR_FLAGS_EN
    check("overflow", 32'(bus.overflow), 1);
    check("underflow_clear", 32'(bus.underflow), 0);
`endif

    // Drain four, then one rejected read.
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      bus.rd_req = 1'b1;
      @(negedge clk);
      check("drain.count", 32'(bus.count), 32'(4 - i));
      check("drain.cr_en", 32'(bus.cr_en), 1);
      check("drain.rvalid", 32'(bus.rvalid), (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) check("drain.rdata", 32'(rdata), 32'(8'hA + i - 1));
      next_cycle();
    end
    @(negedge clk);
    check_flags("empty", 1'b1, 1'b0, 0);
    check("empty.cr_en", 32'(bus.cr_en), 0);
    check("drain.rvalid_last", 32'(bus.rvalid), 1);
    check("drain.rdata_last", 32'(rdata), 32'hD);
    next_cycle();
    bus.rd_req = 1'b0;
    @(negedge clk);
    check("empty.rvalid_low", 32'(bus.rvalid), 0);
    check("empty.r_ptr", 32'(bus.r_ptr), 32'b100);
`ifdef FIFO_ERR_FLAGS_EN
    check("underflow", 32'(bus.underflow), 1);
`endif

    // Empty with both requests: write wins.
    next_cycle();
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    wdata = 8'h11;
    @(negedge clk);
    check("emptyboth.cw_en", 32'(bus.cw_en), 1);
    check("emptyboth.cr_en", 32'(bus.cr_en), 0);
    next_cycle();
    bus.rd_req = 1'b0;
    @(negedge clk);
    check("emptyboth.count", 32'(bus.count), 1);
    for (int i = 0; i < 3; i++) begin
      wdata = 8'(8'h12 + i);
      next_cycle();
    end
    // Full with both requests: read wins.
    bus.rd_req = 1'b1;
    @(negedge clk);
    check_flags("fullboth", 1'b0, 1'b1, 4);
    check("fullboth.cw_en", 32'(bus.cw_en), 0);
    check("fullboth.cr_en", 32'(bus.cr_en), 1);
    next_cycle();
    bus.wr_req = 1'b0;
    @(negedge clk);
    check("fullboth.count", 32'(bus.count), 3);
    check("fullboth.rdata", 32'(rdata), 32'h11);
    next_cycle();
    bus.rd_req = 1'b0;
    @(negedge clk);
    check("pre_steady.count", 32'(bus.count), 2);
    check("pre_steady.w_ptr", 32'(bus.w_ptr), 0);
    check("pre_steady.r_ptr", 32'(bus.r_ptr), 6);

    // Steady write+read at count 2 across both pointer wraps.
    next_cycle();
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wdata = 8'(8'h20 + i);
      @(negedge clk);
      check_flags("steady", 1'b0, 1'b0, 2);
      check("steady.w_ptr", 32'(bus.w_ptr), 32'(i & 7));
      check("steady.r_ptr", 32'(bus.r_ptr), 32'((6 + i) & 7));
      next_cycle();
    end
    bus.rd_req = 1'b0;
    @(negedge clk);
    check("steady.w_end", 32'(bus.w_ptr), 2);
    check("steady.r_end", 32'(bus.r_ptr), 0);
    next_cycle();
    bus.wr_req = 1'b0;
    @(negedge clk);
    check("prerst.count", 32'(bus.count), 3);

    // Reset mid-operation with both requests active.
    next_cycle();
    rst = 1'b1;
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    @(negedge clk);
    check("rst2.cw_en", 32'(bus.cw_en), 0);
    check("rst2.cr_en", 32'(bus.cr_en), 0);
    next_cycle();
    rst = 1'b0;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    @(negedge clk);
    check_flags("rst2", 1'b1, 1'b0, 0);
    check("rst2.w_ptr", 32'(bus.w_ptr), 0);
    check("rst2.r_ptr", 32'(bus.r_ptr), 0);
    check("rst2.rvalid", 32'(bus.rvalid), 0);
`ifdef FIFO_ERR_FLAGS_EN
    check("rst2.overflow", 32'(bus.overflow), 0);
    check("rst2.underflow", 32'(bus.underflow), 0);
`endif
    next_cycle();
    bus.wr_req = 1'b1;
    wdata = 8'h5A;
    @(negedge clk);
    check("postrst.cw_en", 32'(bus.cw_en), 1);
    check("postrst.w_addr", 32'(bus.w_ptr), 0);
    next_cycle();
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b1;
    @(negedge clk);
    check("postrst.cr_en", 32'(bus.cr_en), 1);
    next_cycle();
    bus.rd_req = 1'b0;
    @(negedge clk);
    check("postrst.rvalid", 32'(bus.rvalid), 1);
    check("postrst.rdata", 32'(rdata), 32'h5A);
    check_flags("postrst", 1'b1, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
